// File: rtl/mc_regctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_regctl_pkg
// Description : Shared register map, ID value, FSM encoding and pin indices
//               for the MCU register controller. Optional macro:
//               MC_REGCTL_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_regctl_pkg;

   localparam int unsigned C_ADDR_ID       = 32'h00;
   localparam int unsigned C_ADDR_BUF_OE   = 32'h10;
   localparam int unsigned C_ADDR_BUF_OD   = 32'h11;
   localparam int unsigned C_ADDR_BUF_DIR  = 32'h12;
   localparam int unsigned C_ADDR_BUF_DOUT = 32'h13;
   localparam int unsigned C_ADDR_BUF_DIN  = 32'h14;
   localparam int unsigned C_ADDR_IRQ_MASK = 32'h15;
   localparam int unsigned C_ADDR_IRQ_STAT = 32'h16;
   localparam int unsigned C_ADDR_PWM_ON   = 32'h18;
   localparam int unsigned C_ADDR_PWM_OFF  = 32'h19;
   localparam int unsigned C_ADDR_CTRL     = 32'h1A;

   localparam logic [15:0] C_ID_VALUE = 16'hB9A1;

   // Bit order of every buf_* vector: {aux, cs, miso, clock, mosi}
   localparam int C_PIN_MOSI  = 0;
   localparam int C_PIN_CLOCK = 1;
   localparam int C_PIN_MISO  = 2;
   localparam int C_PIN_CS    = 3;
   localparam int C_PIN_AUX   = 4;
   localparam int C_PIN_W     = C_PIN_AUX + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   function automatic logic [15:0] pin_ext(input logic [C_PIN_W-1:0] v);
      return 16'(v);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_regctl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_regctl_if
// Description : Asynchronous MCU parallel bus (active-low strobes) with
//               master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_regctl_if #(
   parameter int MC_DATA_WIDTH = 16,
   parameter int MC_ADD_WIDTH  = 6
);
   logic                     mc_ce;
   logic                     mc_we;
   logic                     mc_oe;
   logic [MC_ADD_WIDTH-1:0]  mc_add;
   logic [MC_DATA_WIDTH-1:0] mc_din;
   logic [MC_DATA_WIDTH-1:0] mc_dout;
   logic                     mc_doe;

   modport master (
      output mc_ce, mc_we, mc_oe, mc_add, mc_din,
      input  mc_dout, mc_doe
   );

   modport slave (
      input  mc_ce, mc_we, mc_oe, mc_add, mc_din,
      output mc_dout, mc_doe
   );
endinterface
`default_nettype wire

// File: rtl/mc_regctl_sync.sv
`default_nettype none
// ============================================================================
// Module      : mc_sync
// Description : N-stage flop synchronizer, resets to logic 1 (strobe idle).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_sync #(
   parameter int N = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);
   logic [N-1:0] r_ff;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ff <= '1;
      end else begin
         r_ff <= {r_ff[N-2:0], i_d};
      end
   end

   assign o_q = r_ff[N-1];
endmodule
`default_nettype wire

// File: rtl/mc_regctl.sv
`default_nettype none
// ============================================================================
// Module      : mc_regctl
// Description : MCU-bus register controller for IO buffers and PWM shadows.
//               Optional macro MC_REGCTL_IRQ_EN adds IRQ mask/status.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_regctl
   import mc_regctl_pkg::*;
#(
   parameter int MC_DATA_WIDTH = 16,
   parameter int MC_ADD_WIDTH  = 6,
   parameter int SYNC_STAGES   = 2
) (
   input  logic               clock,
   input  logic               reset,
   mc_regctl_if.slave         bus,
   input  logic               pwm_period_end,
   output logic [15:0]        pwm_on,
   output logic [15:0]        pwm_off,
   output logic [C_PIN_W-1:0] buf_oe,
   output logic [C_PIN_W-1:0] buf_od,
   output logic [C_PIN_W-1:0] buf_dir,
   output logic [C_PIN_W-1:0] buf_dout,
   input  logic [C_PIN_W-1:0] buf_din,
   output logic               irq0_out,
   output logic               irq0_dir
);
   logic                     w_ce_s, w_we_s, w_oe_s;
   logic [MC_ADD_WIDTH-1:0]  w_add;
   logic [MC_DATA_WIDTH-1:0] w_din;
   logic [31:0]              w_add32;
   logic [15:0]              w_din16;
   logic [15:0]              w_rdata;
   logic                     w_wr_en, w_shadow_wr, w_ctrl_go, w_pwm_load;
   state_t                   r_state, w_state_nxt;

   logic [C_PIN_W-1:0] r_buf_oe, r_buf_od, r_buf_dir, r_buf_dout;
   logic [15:0]        r_shadow_on, r_shadow_off, r_pwm_on, r_pwm_off, r_dout;
   logic               r_pending;

   mc_sync #(.N(SYNC_STAGES)) u_sync_ce (.clock(clock), .reset(reset), .i_d(bus.mc_ce), .o_q(w_ce_s));
   mc_sync #(.N(SYNC_STAGES)) u_sync_we (.clock(clock), .reset(reset), .i_d(bus.mc_we), .o_q(w_we_s));
   mc_sync #(.N(SYNC_STAGES)) u_sync_oe (.clock(clock), .reset(reset), .i_d(bus.mc_oe), .o_q(w_oe_s));

   assign w_add   = bus.mc_add;
   assign w_din   = bus.mc_din;
   assign w_add32 = 32'(w_add);
   assign w_din16 = 16'(w_din);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // HOLD absorbs the rest of a write strobe so each assertion commits once
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!w_ce_s && !w_we_s) begin
               w_state_nxt = S_WRITE;
            end else if (!w_ce_s && !w_oe_s) begin
               w_state_nxt = S_READ;
            end
         end
         S_WRITE: w_state_nxt = S_HOLD;
         S_HOLD: begin
            if (w_ce_s || (w_we_s && w_oe_s)) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_READ: begin
            if (w_ce_s || w_oe_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_wr_en     = (r_state == S_IDLE) && (w_state_nxt == S_WRITE);
   assign w_shadow_wr = w_wr_en && ((w_add32 == C_ADDR_PWM_ON) || (w_add32 == C_ADDR_PWM_OFF));
   assign w_ctrl_go   = w_wr_en && (w_add32 == C_ADDR_CTRL) && w_din16[0];
   assign w_pwm_load  = w_ctrl_go || (pwm_period_end && r_pending);

`ifdef MC_REGCTL_IRQ_EN
   logic [C_PIN_W-1:0] r_irq_mask, r_irq_stat, r_din_prev, w_stat_clr;

   assign w_stat_clr = (w_wr_en && (w_add32 == C_ADDR_IRQ_STAT)) ? w_din16[C_PIN_W-1:0] : '0;

   // A new rising edge wins over a simultaneous write-one-to-clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_irq_mask <= '0;
         r_irq_stat <= '0;
         r_din_prev <= '0;
      end else begin
         r_din_prev <= buf_din;
         r_irq_stat <= (r_irq_stat & ~w_stat_clr) | (buf_din & ~r_din_prev & r_irq_mask);
         if (w_wr_en && (w_add32 == C_ADDR_IRQ_MASK)) begin
            r_irq_mask <= w_din16[C_PIN_W-1:0];
         end
      end
   end

   assign irq0_out = |r_irq_stat;
`else
   assign irq0_out = 1'b0;
`endif

   always_comb begin
      w_rdata = '0;
      case (w_add32)
         C_ADDR_ID:       w_rdata = C_ID_VALUE;
         C_ADDR_BUF_OE:   w_rdata = pin_ext(r_buf_oe);
         C_ADDR_BUF_OD:   w_rdata = pin_ext(r_buf_od);
         C_ADDR_BUF_DIR:  w_rdata = pin_ext(r_buf_dir);
         C_ADDR_BUF_DOUT: w_rdata = pin_ext(r_buf_dout);
         C_ADDR_BUF_DIN:  w_rdata = pin_ext(buf_din);
`ifdef MC_REGCTL_IRQ_EN
         C_ADDR_IRQ_MASK: w_rdata = pin_ext(r_irq_mask);
         C_ADDR_IRQ_STAT: w_rdata = pin_ext(r_irq_stat);
`endif
         C_ADDR_PWM_ON:   w_rdata = r_shadow_on;
         C_ADDR_PWM_OFF:  w_rdata = r_shadow_off;
         C_ADDR_CTRL:     w_rdata = {15'b0, r_pending};
         default:         w_rdata = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_buf_oe     <= '0;
         r_buf_od     <= '0;
         r_buf_dir    <= '0;
         r_buf_dout   <= '0;
         r_shadow_on  <= '0;
         r_shadow_off <= '0;
         r_pwm_on     <= '0;
         r_pwm_off    <= '0;
         r_pending    <= 1'b0;
         r_dout       <= '0;
      end else begin
         if (w_wr_en) begin
            case (w_add32)
               C_ADDR_BUF_OE:   r_buf_oe     <= w_din16[C_PIN_W-1:0];
               C_ADDR_BUF_OD:   r_buf_od     <= w_din16[C_PIN_W-1:0];
               C_ADDR_BUF_DIR:  r_buf_dir    <= w_din16[C_PIN_W-1:0];
               C_ADDR_BUF_DOUT: r_buf_dout   <= w_din16[C_PIN_W-1:0];
               C_ADDR_PWM_ON:   r_shadow_on  <= w_din16;
               C_ADDR_PWM_OFF:  r_shadow_off <= w_din16;
               default: ;
            endcase
         end
         // Loads see the pre-write shadows; a coinciding shadow write re-arms pending
         if (w_pwm_load) begin
            r_pwm_on  <= r_shadow_on;
            r_pwm_off <= r_shadow_off;
         end
         if (w_shadow_wr) begin
            r_pending <= 1'b1;
         end else if (w_pwm_load) begin
            r_pending <= 1'b0;
         end
         if (w_state_nxt == S_READ) begin
            r_dout <= w_rdata;
         end
      end
   end

   assign bus.mc_doe  = (r_state == S_READ);
   assign bus.mc_dout = MC_DATA_WIDTH'(r_dout);
   assign pwm_on      = r_pwm_on;
   assign pwm_off     = r_pwm_off;
   assign buf_oe      = r_buf_oe;
   assign buf_od      = r_buf_od;
   assign buf_dir     = r_buf_dir;
   assign buf_dout    = r_buf_dout;
   assign irq0_dir    = 1'b1;
endmodule
`default_nettype wire
